// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state codes, frame width
// and the default bit period used by both transmit and receive paths.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_CLK_CYCLES = 4167;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE      = 3'd0;
    localparam uart_state_t ST_START     = 3'd1;
    localparam uart_state_t ST_DATA      = 3'd2;
    localparam uart_state_t ST_STOP      = 3'd3;
    localparam uart_state_t ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_receiver_bit_sync.sv
// bit_sync: 2-flop synchroniser, resets to all-ones (idle-high lines).
// Ports: clk, rst_n, d_i[WIDTH] async input, q_o[WIDTH] synchronised.
module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 deserialiser with one-cycle valid / frame_err strobes.
// Ports: clk, rst_n, uart_rx (async pin), data[8], valid, frame_err.
// Macro UART_RX_MAJORITY_EN: 2-of-3 vote over the last three rxs samples.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_CYCLES = UART_CLK_CYCLES,
    parameter int CTR_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err
);

    localparam int CW = $clog2(UART_DATA_BITS);

    localparam logic [CTR_WIDTH-1:0] HALF_T = CTR_WIDTH'(CLK_CYCLES / 2 - 1);
    localparam logic [CTR_WIDTH-1:0] FULL_T = CTR_WIDTH'(CLK_CYCLES - 1);
    localparam logic [CW-1:0]        LAST_B = CW'(UART_DATA_BITS - 1);

    logic rxs;
    logic bit_s;

    uart_state_t               state_q, state_d;
    logic [CTR_WIDTH-1:0]      timer_q, timer_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;

    bit_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (uart_rx),
        .q_o   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    // rxs one and two cycles back, so at timer == target the vote
    // covers target-2, target-1 and target.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign bit_s = (rxs & hist_q[0])
                 | (rxs & hist_q[1])
                 | (hist_q[0] & hist_q[1]);
`else
    assign bit_s = rxs;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == HALF_T) begin
                    if (bit_s) begin
                        // line went back high: glitch, not a start bit
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = '0;
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end else begin
                    timer_d = timer_q + CTR_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    sh_d    = {bit_s, sh_q[UART_DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_B) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    timer_d = timer_q + CTR_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    if (bit_s) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // hold off until the line idles so a break
                        // is not decoded as a run of 0x00 bytes
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + CTR_WIDTH'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: serial line model driving 8N1 frames
// at 16 clocks per bit, with an event log compared to a byte-level model.
module tb_uart_receiver;

    localparam int BT = 16;
    localparam int LAT = 2 + 1 + BT / 2 + 9 * BT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit both_seen = 1'b0;
    logic [7:0] exp_data = 8'h00;

    // event log: kind 0 = valid, 1 = frame_err
    int         ev_k[$];
    logic [7:0] ev_d[$];
    int         ev_c[$];

    uart_receiver #(
        .CLK_CYCLES (BT),
        .CTR_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                ev_k.push_back(0);
                ev_d.push_back(data);
                ev_c.push_back(cyc);
            end
            if (frame_err) begin
                ev_k.push_back(1);
                ev_d.push_back(data);
                ev_c.push_back(cyc);
            end
            if (valid && frame_err) both_seen = 1'b1;
        end
    end

    // Byte the receiver should report: a single-cycle glitch at the
    // centre of data bit gbit flips it unless majority voting is on.
    function automatic logic [7:0] rx_model(input logic [7:0] b, input int gbit);
        logic [7:0] r;
        r = b;
`ifndef UART_RX_MAJORITY_EN
        if (gbit >= 0) r[gbit] = ~r[gbit];
`endif
        return r;
    endfunction

    task automatic clear_log();
        ev_k.delete();
        ev_d.delete();
        ev_c.delete();
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int glitch_at);
        for (int i = 0; i < BT; i++) begin
            uart_rx = (i == glitch_at) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit);
        start_cyc = cyc;
        drive_bit(1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            drive_bit(b[k], (k == gbit) ? BT / 2 : -1);
        end
        drive_bit(stop, -1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h want 00", data);
        end
        n_tests++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got v=%b fe=%b want 0 0", valid, frame_err);
        end
        rst_n = 1'b1;
        exp_data = 8'h00;
        idle(8);
    endtask

    task automatic test_clean();
        int lat;
        clear_log();
        send_frame(8'hA5, 1'b1, -1);
        idle(BT);
        exp_data = 8'hA5;
        n_tests++;
        if (ev_k.size() !== 1 || (ev_k.size() > 0 && ev_k[0] !== 0)) begin
            n_fail++;
            $display("FAIL clean_events got n=%0d want one valid", ev_k.size());
        end
        n_tests++;
        if (data !== exp_data) begin
            n_fail++;
            $display("FAIL clean_data got %h want %h", data, exp_data);
        end
        if (ev_c.size() > 0) begin
            lat = ev_c[0] - start_cyc;
            n_tests++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                n_fail++;
                $display("FAIL clean_latency got %0d want %0d+-1", lat, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(BT);
        exp_data = 8'hFF;
        n_tests++;
        if (ev_k.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 2", ev_k.size());
        end else begin
            n_tests++;
            if (ev_k[0] !== 0 || ev_k[1] !== 0) begin
                n_fail++;
                $display("FAIL b2b_kind got %0d %0d want 0 0", ev_k[0], ev_k[1]);
            end
            n_tests++;
            if (ev_d[0] !== 8'h00 || ev_d[1] !== 8'hFF) begin
                n_fail++;
                $display("FAIL b2b_data got %h %h want 00 ff", ev_d[0], ev_d[1]);
            end
            n_tests++;
            if (ev_c[1] - ev_c[0] !== 10 * BT) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d want %0d", ev_c[1] - ev_c[0], 10 * BT);
            end
        end
    endtask

    task automatic test_glitch();
        clear_log();
        uart_rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(3 * BT);
        n_tests++;
        if (ev_k.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_strobe got %0d events want 0", ev_k.size());
        end
        send_frame(8'h3C, 1'b1, -1);
        idle(BT);
        exp_data = 8'h3C;
        n_tests++;
        if (ev_k.size() !== 1 || data !== exp_data) begin
            n_fail++;
            $display("FAIL glitch_next got n=%0d data=%h want 1 %h", ev_k.size(), data, exp_data);
        end
    endtask

    task automatic test_frame_err();
        clear_log();
        send_frame(8'h55, 1'b0, -1);
        uart_rx = 1'b0;
        repeat (40 * BT) begin
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (ev_k.size() !== 1 || (ev_k.size() > 0 && ev_k[0] !== 1)) begin
            n_fail++;
            $display("FAIL ferr_events got n=%0d want one frame_err", ev_k.size());
        end
        n_tests++;
        if (data !== exp_data) begin
            n_fail++;
            $display("FAIL ferr_data got %h want %h", data, exp_data);
        end
        idle(2 * BT);
        clear_log();
        send_frame(8'h81, 1'b1, -1);
        idle(BT);
        exp_data = 8'h81;
        n_tests++;
        if (ev_k.size() !== 1 || data !== exp_data) begin
            n_fail++;
            $display("FAIL ferr_recover got n=%0d data=%h want 1 %h", ev_k.size(), data, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h12;
        clear_log();
        drive_bit(1'b0, -1);
        for (int k = 0; k < 3; k++) drive_bit(b[k], -1);
        for (int i = 0; i < BT / 2; i++) begin
            uart_rx = b[3];
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_data = 8'h00;
        n_tests++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h %b %b want 00 0 0", data, valid, frame_err);
        end
        rst_n = 1'b1;
        idle(12 * BT);
        n_tests++;
        if (ev_k.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_strobe got %0d events want 0", ev_k.size());
        end
        send_frame(8'h7E, 1'b1, -1);
        idle(BT);
        exp_data = 8'h7E;
        n_tests++;
        if (ev_k.size() !== 1 || data !== exp_data) begin
            n_fail++;
            $display("FAIL midreset_next got n=%0d data=%h want 1 %h", ev_k.size(), data, exp_data);
        end
    endtask

    task automatic test_majority();
        clear_log();
        send_frame(8'hC3, 1'b1, 3);
        idle(BT);
        exp_data = rx_model(8'hC3, 3);
        n_tests++;
        if (ev_k.size() !== 1 || data !== exp_data) begin
            n_fail++;
            $display("FAIL glitch_bit3 got n=%0d data=%h want 1 %h", ev_k.size(), data, exp_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        int         gap;
        for (int f = 0; f < 16; f++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap = stop ? $urandom_range(0, 40) : $urandom_range(2, 40);
            clear_log();
            send_frame(b, stop, -1);
            if (stop) exp_data = b;
            n_tests++;
            if (ev_k.size() !== 1 || (ev_k.size() > 0 && ev_k[0] !== (stop ? 0 : 1))) begin
                n_fail++;
                $display("FAIL rand%0d_event got n=%0d want kind %0d", f, ev_k.size(), stop ? 0 : 1);
            end
            n_tests++;
            if (data !== exp_data) begin
                n_fail++;
                $display("FAIL rand%0d_data got %h want %h", f, data, exp_data);
            end
            idle(gap);
        end
        idle(BT);
        n_tests++;
        if (both_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_overlap got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_majority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
